// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   Receives asynchronous serial frames using an 8x oversample strobe.
//   The line is sampled once per bit, at the centre tick (phase == 3).
//   Optional even parity is compiled in with the UART_RX_PARITY_EN macro.
//   When the macro is undefined, the frame is start, DATA_BITS data and stop.
//
// Ports
//   clk        : sole clock.
//   rst        : asynchronous, active-high reset.
//   tick       : 8x-baud oversample strobe, one clk wide.
//   rx         : asynchronous serial line, idle high.
//   data       : last received word, LSB received first.
//   data_valid : one-clk pulse for a good frame.
//   frame_err  : one-clk pulse when the stop bit is sampled low.
//   parity_err : one-clk pulse on parity mismatch (0 without parity).
//   busy       : high whenever the receiver is not idle.
//
// FSM states
//   state    | meaning
//   IDLE     | waiting for a falling edge on the synchronized line
//   START    | confirming the start bit at its centre
//   DATA     | shifting data bits in, LSB first
//   PARITY   | checking the even-parity bit (UART_RX_PARITY_EN only)
//   STOP     | sampling the stop bit, publishing the word and outcome

module uart_rx_oversampled #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    logic [2:0]           phase_q, phase_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
    logic                 pe_q, pe_d;
    logic                 par_bad_q, par_bad_d;
`endif

    logic fall;
    logic sample;

    // Edge detection needs the previous synchronized value to be high, so
    // after a frame error the line must recover before a new start is seen.
    assign fall   = rxs_prev_q & ~rxs_q;
    assign sample = tick && (phase_q == 3'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            phase_q    <= 3'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q       <= 1'b0;
            par_bad_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            fe_q       <= fe_d;
`ifdef UART_RX_PARITY_EN
            pe_q       <= pe_d;
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d      = 1'b0;
        par_bad_d = par_bad_q;
`endif
        if (state_q != S_IDLE && tick) begin
            phase_d = phase_q + 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                // Phase is held at 0 here, so a tick coincident with the
                // falling edge cannot advance it.
                phase_d   = 3'd0;
                bit_idx_d = 3'd0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample) begin
                    par_bad_d = rxs_q ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit of margin for a
                // back-to-back start edge.
                if (sample) begin
                    data_d  = shift_q;
                    state_d = S_IDLE;
                    if (!rxs_q) begin
                        fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        pe_d = 1'b1;
`endif
                    end else begin
                        dv_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        data       = data_q;
        data_valid = dv_q;
        frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
        parity_err = pe_q;
`else
        parity_err = 1'b0;
`endif
    end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port tick  input  1  8x-baud oversample strobe, one clk wide, from baud_tick_gen with oversampling=8.
REQ-005 Port rx  input  1  asynchronous serial line; idle high.
REQ-006 Port data  output  DATA_BITS  last received word, LSB received first.
REQ-007 Port data_valid  output  1  one-clk pulse when a frame with a good stop bit (and good parity, if enabled) completes.
REQ-008 Port frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-009 Port parity_err  output  1  one-clk pulse on parity mismatch; constant 0 when parity is compiled out.
REQ-010 Port busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer; all decisions use the synchronized value rxs.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: a high-to-low transition of rxs SHALL enter START and clear the 3-bit tick phase counter, regardless of tick.
REQ-014 Phase counter SHALL increment only on tick and wrap 7->0; the bit sample point is the tick at which phase==3.
REQ-015 START: at sample point, rxs==0 -> DATA with bit index 0; rxs==1 -> IDLE (false start, no output pulse).
REQ-016 DATA: each sample point SHALL shift rxs into the word LSB-first; after bit DATA_BITS-1 go to PARITY if enabled, else STOP.
REQ-017 PARITY: at sample point compare rxs with even parity of the data bits; then go to STOP.
REQ-018 STOP: at sample point, load data with the assembled word, return to IDLE, and pulse exactly one outcome on the next clk: frame_err if rxs==0; else parity_err on mismatch; else data_valid.
REQ-019 data SHALL be updated only on the STOP sample and SHALL hold between frames.
REQ-020 Return to IDLE at mid-stop-bit SHALL allow a back-to-back start bit to be detected with no lost frame.
REQ-021 After a frame error, the next frame SHALL require rxs to return high before a new falling edge is accepted.
REQ-022 Pulses on data_valid, frame_err, parity_err SHALL never exceed one clk and SHALL be mutually exclusive.
REQ-023 A tick coincident with the falling edge in IDLE SHALL NOT advance the phase counter.

Reset
REQ-024 rst high SHALL asynchronously force state IDLE, phase 0, bit index 0, data 0, data_valid 0, frame_err 0, parity_err 0, busy 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes on the first falling edge after rst deasserts.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame = start, DATA_BITS data, one even-parity bit, one stop; PARITY state and parity_err active.
REQ-027 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame = start, DATA_BITS data, stop; parity_err tied 0.

Verification
REQ-028 12 MHz clk, 115200x8 ticks, send 0xA5, good stop -> data=0xA5, single data_valid pulse, busy low afterwards.
REQ-029 Send 0x3C then 0xC3 back-to-back (stop bit directly followed by start) -> two data_valid pulses, data=0x3C then 0xC3.
REQ-030 rx low for 2 ticks then high (glitch) -> no pulses, busy returns low after the phase-3 sample, data unchanged.
REQ-031 Send 0x55 with stop bit forced low -> frame_err pulse, no data_valid; next good 0x12 frame -> data_valid, data=0x12.
REQ-032 Assert rst during bit 4 of 0xFF -> all outputs 0 immediately; subsequent 0x81 frame -> data_valid, data=0x81.
REQ-033 UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (wrong) -> parity_err pulse, no data_valid; with parity bit 1 -> data_valid, data=0x07.
